// File: rtl/digit_serial_adder_if.sv
// Request/result bundle between a client and digit_serial_adder.
// Optional DIGIT_SERIAL_SUB_EN adds the sub request bit.
interface digit_serial_adder_if #(
    parameter int WIDTH = 8
);
    // Handshake: start is taken on any edge where busy is low; a, b, cin (and sub)
    // are captured on that edge. done pulses for one cycle when sum/cout are valid.
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef DIGIT_SERIAL_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [1:0]       dbg_state;

    modport master (
`ifdef DIGIT_SERIAL_SUB_EN
        output sub,
`endif
        output start, a, b, cin,
        input  busy, done, sum, cout, dbg_state
    );

    modport slave (
`ifdef DIGIT_SERIAL_SUB_EN
        input  sub,
`endif
        input  start, a, b, cin,
        output busy, done, sum, cout, dbg_state
    );
endinterface

// File: rtl/digit_serial_adder.sv
// Wide adder built on a single 2-bit digit stage, LS digit first, WIDTH/2 cycles per add.
// Optional DIGIT_SERIAL_SUB_EN: sub request turns the add into a - b.
module digit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    digit_serial_adder_if.slave  bus
);
    localparam int D  = WIDTH / 2;
    localparam int CW = (D > 1) ? $clog2(D) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(D - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [2:0]       digit_sum;
    logic [WIDTH+1:0] sum_ext;

    // The one shared 2-bit full-adder stage.
    assign digit_sum = {1'b0, a_sh_q[1:0]} + {1'b0, b_sh_q[1:0]} + {2'b00, carry_q};
    assign sum_ext   = {digit_sum[1:0], sum_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    a_sh_d  = bus.a;
                    sum_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef DIGIT_SERIAL_SUB_EN
                    b_sh_d  = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub ? 1'b1 : bus.cin;
`else
                    b_sh_d  = bus.b;
                    carry_d = bus.cin;
`endif
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_sh_d  = a_sh_q >> 2;
                b_sh_d  = b_sh_q >> 2;
                sum_d   = sum_ext[WIDTH+1:2];
                carry_d = digit_sum[2];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cout_d  = digit_sum[2];
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.dbg_state = state_q;
endmodule
